// File: rtl/zelda_sprite_pkg.sv
// Shared screen geometry, transparency index and pixel types for the sprite path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package zelda_sprite_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [9:0] coord_t;
   typedef logic [3:0] pal_idx_t;

   localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

endpackage

// File: rtl/sprite_anim_ctr.sv
// Walk-cycle animation counter: picks which stored frame of the sprite is shown.
// Latency: frame_idx updates on the clock edge that samples frame_start.
// Backpressure: none; it advances only on frame_start pulses.
module sprite_anim_ctr #(
   parameter int NUM_FRAMES = 2,
   parameter int ANIM_DIV   = 8,
   parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               moving,
   output logic [FRAME_W-1:0] frame_idx
);

   localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   logic [CNT_W-1:0] anim_cnt;

   // Once per video frame: hold the idle pose when standing still, otherwise step the walk cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         anim_cnt  <= '0;
         frame_idx <= '0;
      end else if (frame_start) begin
         if (!moving) begin
            anim_cnt  <= '0;
            frame_idx <= '0;
         end else if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
            anim_cnt  <= '0;
            frame_idx <= (frame_idx == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + FRAME_W'(1);
         end else begin
            anim_cnt  <= anim_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Maps the scan position to a sprite ROM address and returns palette index plus hit flag.
// Latency: 3 clocks from the pixel on DrawX/DrawY to pix_index/pix_hit (rom_addr after 1).
// Backpressure: none; the pipeline advances every clock and never stalls.
module sprite_pixel_fetch
   import zelda_sprite_pkg::*;
#(
   parameter int SPR_W      = 16,
   parameter int SPR_H      = 16,
   parameter int NUM_FRAMES = 2,
   parameter int ANIM_DIV   = 8,
   parameter int ADDR_W     = $clog2(NUM_FRAMES * SPR_W * SPR_H)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_start,
   input  logic              moving,
   input  logic              facing_left,
   input  logic [9:0]        sprite_x,
   input  logic [9:0]        sprite_y,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pix_index,
   output logic              pix_hit
);

   localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   coord_t              pos_x;
   coord_t              pos_y;
   logic                face_l;
   logic [FRAME_W-1:0]  frame_idx;

   logic [10:0]         dx;
   logic [10:0]         dy;
   logic [10:0]         col;
   logic                on_screen;
   logic                in1;
   logic [ADDR_W-1:0]   addr_nxt;

   logic                in1_q;
   logic                in2;

   sprite_anim_ctr #(
      .NUM_FRAMES (NUM_FRAMES),
      .ANIM_DIV   (ANIM_DIV),
      .FRAME_W    (FRAME_W)
   ) u_anim (
      .clk         (Clk),
      .reset       (Reset),
      .frame_start (frame_start),
      .moving      (moving),
      .frame_idx   (frame_idx)
   );

   // Position and facing change only at vertical blank so a frame never shows a torn sprite
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pos_x  <= '0;
         pos_y  <= '0;
         face_l <= 1'b0;
      end else if (frame_start) begin
         pos_x  <= sprite_x;
         pos_y  <= sprite_y;
         face_l <= facing_left;
      end
   end

   // Box test and ROM address; negative offsets wrap to large values and so fall outside the box.
   // The on-screen term keeps a sprite parked beyond the visible area from hitting during blanking.
   always_comb begin
      dx        = {1'b0, DrawX} - {1'b0, pos_x};
      dy        = {1'b0, DrawY} - {1'b0, pos_y};
      on_screen = (DrawX < coord_t'(SCREEN_W)) && (DrawY < coord_t'(SCREEN_H));
      in1       = on_screen && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
      col       = face_l ? (11'(SPR_W - 1) - dx) : dx;
      addr_nxt  = ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(dy) * ADDR_W'(SPR_W)
                + ADDR_W'(col);
   end

   // Three-stage fetch: address out, wait for the ROM, then register index and hit together
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr  <= '0;
         in1_q     <= 1'b0;
         in2       <= 1'b0;
         pix_index <= '0;
         pix_hit   <= 1'b0;
      end else begin
         if (in1) begin
            rom_addr <= addr_nxt;
         end
         in1_q     <= in1;
         in2       <= in1_q;
         pix_index <= rom_q;
         pix_hit   <= in2 && (rom_q != TRANSPARENT_IDX);
      end
   end

endmodule
